// File: rtl/prefetch_cache_pkg.sv
// -----------------------------------------------------------------------------
// prefetch_cache_pkg
// Shared definitions for the two-way cache controller with prefetch-fill
// support: controller state encoding and the mux-select encodings the
// controller drives toward the cache datapath.
// -----------------------------------------------------------------------------
package prefetch_cache_pkg;

    // Controller states. CPU path: IDLE -> CHECK -> (WB) -> FILL -> CHECK.
    // Prefetch path: IDLE -> PF_CHECK -> (PF_WB) -> PF_FILL -> IDLE.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        WB       = 3'd2,
        FILL     = 3'd3,
        PF_CHECK = 3'd4,
        PF_WB    = 3'd5,
        PF_FILL  = 3'd6
    } state_t;

    // data_in_sel: source of the line written into the data arrays
    localparam logic [1:0] DIN_PMEM = 2'b00;
    localparam logic [1:0] DIN_CPU  = 2'b01;
    localparam logic [1:0] DIN_PF   = 2'b11;

    // wr_en_data_N_sel: data-array write enable mode per way
    localparam logic [1:0] WREN_NONE = 2'b00;
    localparam logic [1:0] WREN_LINE = 2'b01;
    localparam logic [1:0] WREN_BYTE = 2'b10;

    // pmem_addr_sel: address presented to the cacheline adapter
    localparam logic PADDR_VICTIM = 1'b0;
    localparam logic PADDR_REQ    = 1'b1;

endpackage

// File: rtl/prefetch_cache_control.sv
// -----------------------------------------------------------------------------
// prefetch_cache_control
// Control FSM for a two-way set-associative cache that also installs lines
// handed over by a prefetcher. CPU requests and prefetch installs are
// arbitrated in IDLE; a starve counter bounds how many CPU grants may pass a
// pending prefetch.
//
// Ports
//   clk, rst               clock (rising edge), async active-low reset
//   mem_read/mem_write     CPU request (held until mem_resp)
//   mem_resp               CPU request complete pulse
//   pmem_read/pmem_write   fill / writeback requests to the cacheline adapter
//   pmem_resp              adapter completion pulse
//   miss, dirty_out, way   datapath lookup results (way = hit way or victim)
//   prefetch_ready         prefetcher holds a line, held until prefetch_ack
//   prefetch_ack           prefetched line consumed or dropped pulse
//   data_in_sel, pmem_addr_sel, wr_en_data_{0,1}_sel, dirty_in, valid_in,
//   ld_dirty_*, ld_valid_*, ld_tag_*, ld_lru, index_sel, tag_sel
//                          datapath controls
// -----------------------------------------------------------------------------
module prefetch_cache_control
    import prefetch_cache_pkg::*;
#(
    parameter int unsigned PF_STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_read,
    input  logic       mem_write,
    output logic       mem_resp,
    output logic       pmem_read,
    output logic       pmem_write,
    input  logic       pmem_resp,
    input  logic       miss,
    input  logic       dirty_out,
    input  logic       way,
    input  logic       prefetch_ready,
    output logic       prefetch_ack,
    output logic [1:0] data_in_sel,
    output logic       pmem_addr_sel,
    output logic [1:0] wr_en_data_0_sel,
    output logic [1:0] wr_en_data_1_sel,
    output logic       dirty_in,
    output logic       valid_in,
    output logic       ld_dirty_0,
    output logic       ld_dirty_1,
    output logic       ld_valid_0,
    output logic       ld_valid_1,
    output logic       ld_tag_0,
    output logic       ld_tag_1,
    output logic       ld_lru,
    output logic       index_sel,
    output logic       tag_sel
);

    localparam int unsigned    CNT_W   = $clog2(PF_STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(PF_STARVE_LIMIT);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_cpu_req;
    logic             w_grant_cpu;
    logic             w_grant_pf;

    assign w_cpu_req   = mem_read | mem_write;
    assign w_grant_cpu = (r_state == IDLE) && (w_next_state == CHECK);
    assign w_grant_pf  = (r_state == IDLE) && (w_next_state == PF_CHECK);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Starve counter: counts CPU grants taken while a prefetch waits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= {CNT_W{1'b0}};
        end else if (w_grant_cpu && prefetch_ready) begin
            if (r_starve_cnt != LIMIT_C) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end else begin
                r_starve_cnt <= r_starve_cnt;
            end
        end else if (w_grant_pf || !prefetch_ready) begin
            r_starve_cnt <= {CNT_W{1'b0}};
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                // CPU wins unless a prefetch has already been passed over too often
                if (w_cpu_req && (!prefetch_ready || (r_starve_cnt < LIMIT_C))) begin
                    w_next_state = CHECK;
                end else if (prefetch_ready) begin
                    w_next_state = PF_CHECK;
                end else begin
                    w_next_state = IDLE;
                end
            end
            CHECK: begin
                if (!miss) begin
                    w_next_state = IDLE;
                end else if (dirty_out) begin
                    w_next_state = WB;
                end else begin
                    w_next_state = FILL;
                end
            end
            WB: begin
                if (pmem_resp) begin
                    w_next_state = FILL;
                end else begin
                    w_next_state = WB;
                end
            end
            FILL: begin
                // Return to CHECK so the request completes as a normal hit
                if (pmem_resp) begin
                    w_next_state = CHECK;
                end else begin
                    w_next_state = FILL;
                end
            end
            PF_CHECK: begin
                if (!miss) begin
                    w_next_state = IDLE;
                end else if (dirty_out) begin
                    w_next_state = PF_WB;
                end else begin
                    w_next_state = PF_FILL;
                end
            end
            PF_WB: begin
                if (pmem_resp) begin
                    w_next_state = PF_FILL;
                end else begin
                    w_next_state = PF_WB;
                end
            end
            PF_FILL: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Output decode; everything is forced low while reset is asserted so no
    // array load can fire in the reset cycle
    always_comb begin
        mem_resp         = 1'b0;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        prefetch_ack     = 1'b0;
        data_in_sel      = DIN_PMEM;
        pmem_addr_sel    = PADDR_VICTIM;
        wr_en_data_0_sel = WREN_NONE;
        wr_en_data_1_sel = WREN_NONE;
        dirty_in         = 1'b0;
        valid_in         = 1'b0;
        ld_dirty_0       = 1'b0;
        ld_dirty_1       = 1'b0;
        ld_valid_0       = 1'b0;
        ld_valid_1       = 1'b0;
        ld_tag_0         = 1'b0;
        ld_tag_1         = 1'b0;
        ld_lru           = 1'b0;
        index_sel        = 1'b0;
        tag_sel          = 1'b0;
        if (rst) begin
            case (r_state)
                IDLE: begin
                    mem_resp = 1'b0;
                end
                CHECK: begin
                    if (!miss) begin
                        mem_resp = 1'b1;
                        ld_lru   = 1'b1;
                        if (mem_write) begin
                            data_in_sel = DIN_CPU;
                            dirty_in    = 1'b1;
                            if (way) begin
                                wr_en_data_1_sel = WREN_BYTE;
                                ld_dirty_1       = 1'b1;
                            end else begin
                                wr_en_data_0_sel = WREN_BYTE;
                                ld_dirty_0       = 1'b1;
                            end
                        end else begin
                            data_in_sel = DIN_PMEM;
                        end
                    end else begin
                        mem_resp = 1'b0;
                    end
                end
                WB: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = PADDR_VICTIM;
                end
                FILL: begin
                    pmem_read     = 1'b1;
                    pmem_addr_sel = PADDR_REQ;
                    if (pmem_resp) begin
                        data_in_sel = DIN_PMEM;
                        valid_in    = 1'b1;
                        dirty_in    = 1'b0;
                        if (way) begin
                            wr_en_data_1_sel = WREN_LINE;
                            ld_tag_1         = 1'b1;
                            ld_valid_1       = 1'b1;
                            ld_dirty_1       = 1'b1;
                        end else begin
                            wr_en_data_0_sel = WREN_LINE;
                            ld_tag_0         = 1'b1;
                            ld_valid_0       = 1'b1;
                            ld_dirty_0       = 1'b1;
                        end
                    end else begin
                        valid_in = 1'b0;
                    end
                end
                PF_CHECK: begin
                    index_sel = 1'b1;
                    tag_sel   = 1'b1;
                    // Line already present: drop the prefetch without touching arrays
                    if (!miss) begin
                        prefetch_ack = 1'b1;
                    end else begin
                        prefetch_ack = 1'b0;
                    end
                end
                PF_WB: begin
                    index_sel     = 1'b1;
                    tag_sel       = 1'b1;
                    pmem_write    = 1'b1;
                    pmem_addr_sel = PADDR_VICTIM;
                end
                PF_FILL: begin
                    // No LRU update: the prefetched line stays eligible for eviction
                    index_sel    = 1'b1;
                    tag_sel      = 1'b1;
                    data_in_sel  = DIN_PF;
                    valid_in     = 1'b1;
                    dirty_in     = 1'b0;
                    prefetch_ack = 1'b1;
                    if (way) begin
                        wr_en_data_1_sel = WREN_LINE;
                        ld_tag_1         = 1'b1;
                        ld_valid_1       = 1'b1;
                        ld_dirty_1       = 1'b1;
                    end else begin
                        wr_en_data_0_sel = WREN_LINE;
                        ld_tag_0         = 1'b1;
                        ld_valid_0       = 1'b1;
                        ld_dirty_0       = 1'b1;
                    end
                end
                default: begin
                    mem_resp = 1'b0;
                end
            endcase
        end else begin
            mem_resp = 1'b0;
        end
    end

endmodule

// File: tb/tb_prefetch_cache_control.sv
// -----------------------------------------------------------------------------
// tb_prefetch_cache_control
// Directed stimulus against prefetch_cache_control with a transaction-level
// reference model checked on every falling edge, plus literal expectations
// at the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_prefetch_cache_control;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_read = 1'b0, mem_write = 1'b0, pmem_resp = 1'b0;
    logic miss = 1'b0, dirty_out = 1'b0, way = 1'b0, prefetch_ready = 1'b0;
    logic mem_resp, pmem_read, pmem_write, prefetch_ack;
    logic [1:0] data_in_sel, wr_en_data_0_sel, wr_en_data_1_sel;
    logic pmem_addr_sel, dirty_in, valid_in;
    logic ld_dirty_0, ld_dirty_1, ld_valid_0, ld_valid_1, ld_tag_0, ld_tag_1;
    logic ld_lru, index_sel, tag_sel;

    prefetch_cache_control #(.PF_STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .miss(miss), .dirty_out(dirty_out), .way(way),
        .prefetch_ready(prefetch_ready), .prefetch_ack(prefetch_ack),
        .data_in_sel(data_in_sel), .pmem_addr_sel(pmem_addr_sel),
        .wr_en_data_0_sel(wr_en_data_0_sel), .wr_en_data_1_sel(wr_en_data_1_sel),
        .dirty_in(dirty_in), .valid_in(valid_in),
        .ld_dirty_0(ld_dirty_0), .ld_dirty_1(ld_dirty_1),
        .ld_valid_0(ld_valid_0), .ld_valid_1(ld_valid_1),
        .ld_tag_0(ld_tag_0), .ld_tag_1(ld_tag_1),
        .ld_lru(ld_lru), .index_sel(index_sel), .tag_sel(tag_sel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_resp;
        logic       pmem_read;
        logic       pmem_write;
        logic       prefetch_ack;
        logic [1:0] data_in_sel;
        logic       pmem_addr_sel;
        logic [1:0] wr0;
        logic [1:0] wr1;
        logic       dirty_in;
        logic       valid_in;
        logic       ld_dirty_0;
        logic       ld_dirty_1;
        logic       ld_valid_0;
        logic       ld_valid_1;
        logic       ld_tag_0;
        logic       ld_tag_1;
        logic       ld_lru;
        logic       index_sel;
        logic       tag_sel;
    } outs_t;

    outs_t act;
    assign act = {mem_resp, pmem_read, pmem_write, prefetch_ack, data_in_sel,
                  pmem_addr_sel, wr_en_data_0_sel, wr_en_data_1_sel, dirty_in,
                  valid_in, ld_dirty_0, ld_dirty_1, ld_valid_0, ld_valid_1,
                  ld_tag_0, ld_tag_1, ld_lru, index_sel, tag_sel};

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Activity: waiting, looking up, evicting, loading; m_pf says whether the
    // activity serves the prefetcher rather than the CPU.
    typedef enum {PH_IDLE, PH_LOOKUP, PH_EVICT, PH_LOAD} phase_t;
    phase_t m_ph = PH_IDLE, m_ph_n = PH_IDLE;
    bit     m_pf = 1'b0, m_pf_n = 1'b0;
    int     m_starve = 0, m_starve_n = 0;

    function automatic outs_t install(input outs_t e_in, input logic w, input logic [1:0] src);
        outs_t e = e_in;
        e.data_in_sel = src;
        e.valid_in    = 1'b1;
        e.dirty_in    = 1'b0;
        if (w) begin
            e.wr1 = 2'b01; e.ld_tag_1 = 1'b1; e.ld_valid_1 = 1'b1; e.ld_dirty_1 = 1'b1;
        end else begin
            e.wr0 = 2'b01; e.ld_tag_0 = 1'b1; e.ld_valid_0 = 1'b1; e.ld_dirty_0 = 1'b1;
        end
        return e;
    endfunction

    task automatic model_eval(output outs_t e, output phase_t nph, output bit npf, output int nst);
        bit start_cpu, start_pf;
        e = '0; nph = m_ph; npf = m_pf;
        start_cpu = 1'b0; start_pf = 1'b0;
        case (m_ph)
            PH_IDLE: begin
                if ((mem_read || mem_write) && (!prefetch_ready || m_starve < LIMIT)) begin
                    nph = PH_LOOKUP; npf = 1'b0; start_cpu = 1'b1;
                end else if (prefetch_ready) begin
                    nph = PH_LOOKUP; npf = 1'b1; start_pf = 1'b1;
                end
            end
            PH_LOOKUP: begin
                e.index_sel = m_pf; e.tag_sel = m_pf;
                if (!miss) begin
                    nph = PH_IDLE;
                    if (m_pf) e.prefetch_ack = 1'b1;
                    else begin
                        e.mem_resp = 1'b1; e.ld_lru = 1'b1;
                        if (mem_write) begin
                            e.data_in_sel = 2'b01; e.dirty_in = 1'b1;
                            if (way) begin e.wr1 = 2'b10; e.ld_dirty_1 = 1'b1; end
                            else     begin e.wr0 = 2'b10; e.ld_dirty_0 = 1'b1; end
                        end
                    end
                end else begin
                    nph = dirty_out ? PH_EVICT : PH_LOAD;
                end
            end
            PH_EVICT: begin
                e.index_sel = m_pf; e.tag_sel = m_pf; e.pmem_write = 1'b1;
                if (pmem_resp) nph = PH_LOAD;
            end
            PH_LOAD: begin
                e.index_sel = m_pf; e.tag_sel = m_pf;
                if (m_pf) begin
                    e = install(e, way, 2'b11);
                    e.prefetch_ack = 1'b1;
                    nph = PH_IDLE;
                end else begin
                    e.pmem_read = 1'b1; e.pmem_addr_sel = 1'b1;
                    if (pmem_resp) begin
                        e = install(e, way, 2'b00);
                        nph = PH_LOOKUP;
                    end
                end
            end
            default: nph = PH_IDLE;
        endcase
        if (start_cpu && prefetch_ready) nst = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
        else if (start_pf || !prefetch_ready) nst = 0;
        else nst = m_starve;
    endtask

    // Compare DUT outputs against the model every falling edge
    always @(negedge clk) begin
        outs_t exp_o;
        if (!rst) begin
            exp_o = '0; m_ph_n = PH_IDLE; m_pf_n = 1'b0; m_starve_n = 0;
        end else begin
            model_eval(exp_o, m_ph_n, m_pf_n, m_starve_n);
        end
        check("outputs_vs_model", 32'(act), 32'(exp_o));
    end

    // Advance the model on the active edge
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph <= PH_IDLE; m_pf <= 1'b0; m_starve <= 0;
        end else begin
            m_ph <= m_ph_n; m_pf <= m_pf_n; m_starve <= m_starve_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        bit ack_seen;
        bit fifth;

        // reset state
        at_neg();
        check("reset_outputs", 32'(act), 32'd0);
        tick(); rst = 1'b1;

        // read hit in way 1
        mem_read = 1'b1; miss = 1'b0; way = 1'b1;
        at_neg(); check("hit_idle_no_resp", 32'(mem_resp), 32'd0);
        tick();
        at_neg();
        check("hit_mem_resp", 32'(mem_resp), 32'd1);
        check("hit_ld_lru", 32'(ld_lru), 32'd1);
        check("hit_no_pmem", 32'({pmem_read, pmem_write}), 32'd0);

        // write miss with dirty victim in way 0
        tick(); mem_read = 1'b0; mem_write = 1'b1; miss = 1'b1; dirty_out = 1'b1; way = 1'b0;
        tick();
        tick();
        at_neg();
        check("wb_pmem_write", 32'(pmem_write), 32'd1);
        check("wb_addr_victim", 32'(pmem_addr_sel), 32'd0);
        check("wb_no_read", 32'(pmem_read), 32'd0);
        tick();
        at_neg(); check("wb_hold", 32'(pmem_write), 32'd1);
        tick(); pmem_resp = 1'b1;
        tick(); pmem_resp = 1'b0;
        at_neg();
        check("fill_pmem_read", 32'({pmem_read, pmem_write, pmem_addr_sel}), 32'b101);
        check("fill_wait_no_write", 32'(wr_en_data_0_sel), 32'd0);
        tick(); pmem_resp = 1'b1; miss = 1'b0;
        at_neg();
        check("fill_wr_line", 32'(wr_en_data_0_sel), 32'd1);
        check("fill_loads", 32'({ld_tag_0, ld_valid_0, ld_dirty_0, valid_in, dirty_in}), 32'b11110);
        check("fill_src_pmem", 32'(data_in_sel), 32'd0);
        tick(); pmem_resp = 1'b0;
        at_neg();
        check("wrhit_wr_byte", 32'(wr_en_data_0_sel), 32'd2);
        check("wrhit_dirty", 32'({dirty_in, ld_dirty_0, mem_resp}), 32'b111);
        check("wrhit_src_cpu", 32'(data_in_sel), 32'd1);

        // prefetch install into a clean victim (way 1), no CPU traffic
        tick(); mem_write = 1'b0; dirty_out = 1'b0; prefetch_ready = 1'b1; miss = 1'b1; way = 1'b1;
        tick();
        at_neg();
        check("pfchk_sel", 32'({index_sel, tag_sel, prefetch_ack}), 32'b110);
        tick();
        at_neg();
        check("pffill_src", 32'(data_in_sel), 32'd3);
        check("pffill_ack_lru", 32'({prefetch_ack, ld_lru, pmem_read}), 32'b100);
        check("pffill_wr1", 32'({wr_en_data_1_sel, ld_tag_1}), 32'b011);
        tick(); prefetch_ready = 1'b0;

        // duplicate prefetch: lookup hits, dropped without array writes
        tick(); prefetch_ready = 1'b1; miss = 1'b0;
        tick();
        at_neg();
        check("pfdup_ack", 32'({prefetch_ack, ld_tag_0, ld_tag_1, ld_lru}), 32'b1000);
        tick(); prefetch_ready = 1'b0;

        // prefetch with dirty victim; CPU read arrives mid-sequence and waits
        tick(); prefetch_ready = 1'b1; miss = 1'b1; dirty_out = 1'b1; way = 1'b0;
        tick(); mem_read = 1'b1;
        tick();
        at_neg();
        check("pfwb_write", 32'({pmem_write, index_sel, mem_resp}), 32'b110);
        tick(); pmem_resp = 1'b1;
        tick(); pmem_resp = 1'b0;
        at_neg();
        check("pfwb_then_fill", 32'({prefetch_ack, data_in_sel, wr_en_data_0_sel}), 32'b11101);
        tick(); prefetch_ready = 1'b0; miss = 1'b0; dirty_out = 1'b0;
        tick();
        at_neg(); check("cpu_after_pf", 32'(mem_resp), 32'd1);
        tick(); mem_read = 1'b0;

        // starvation bound: CPU hammers hits while a prefetch waits
        tick(); prefetch_ready = 1'b1; mem_read = 1'b1; miss = 1'b0; way = 1'b0;
        grants = 0; ack_seen = 1'b0;
        for (int i = 0; i < 40 && !ack_seen; i++) begin
            at_neg();
            if (mem_resp) grants++;
            if (prefetch_ack) ack_seen = 1'b1;
            tick();
        end
        prefetch_ready = 1'b0;
        check("starve_ack_seen", 32'(ack_seen), 32'd1);
        check("starve_grants", 32'(grants), 32'(LIMIT));
        fifth = 1'b0;
        for (int i = 0; i < 10 && !fifth; i++) begin
            at_neg();
            if (mem_resp) fifth = 1'b1;
            tick();
        end
        check("starve_fifth_grant", 32'(fifth), 32'd1);
        mem_read = 1'b0;

        // reset asserted mid-fill
        tick(); mem_read = 1'b1; miss = 1'b1; dirty_out = 1'b0; way = 1'b1;
        tick();
        tick();
        at_neg();
        check("fill_before_reset", 32'(pmem_read), 32'd1);
        #2 rst = 1'b0;
        #1 check("reset_async_outputs", 32'(act), 32'd0);
        tick();
        tick(); rst = 1'b1; mem_read = 1'b0; pmem_resp = 1'b1;
        at_neg(); check("post_reset_quiet", 32'(act), 32'd0);
        tick(); pmem_resp = 1'b0; mem_read = 1'b1; miss = 1'b0;
        at_neg(); check("post_reset_idle", 32'(mem_resp), 32'd0);
        tick();
        at_neg(); check("post_reset_hit", 32'(mem_resp), 32'd1);
        tick(); mem_read = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prefetch_cache_control.md
PREFETCH_CACHE_CONTROL -- requirements
Module: prefetch_cache_control

Interface
- REQ-001 SHALL have parameter PF_STARVE_LIMIT, default 4: consecutive CPU grants allowed while prefetch_ready pends.
- REQ-002 SHALL have ports, clock and reset first:
  - clk  in  1  sole clock, rising edge.
  - rst  in  1  reset, asynchronous, active-low.
  - mem_read  in  1  CPU read request, held until mem_resp.
  - mem_write  in  1  CPU write request, held until mem_resp.
  - mem_resp  out  1  CPU request complete, one-cycle pulse.
  - pmem_read  out  1  line fill request to cacheline adapter.
  - pmem_write  out  1  victim writeback request.
  - pmem_resp  in  1  adapter done, one-cycle pulse.
  - miss  in  1  datapath tag compare result.
  - dirty_out  in  1  dirty bit of selected way.
  - way  in  1  hit way, or LRU victim on miss.
  - prefetch_ready  in  1  prefetcher holds a line at pf_cline_address, held until prefetch_ack.
  - prefetch_ack  out  1  prefetched line consumed or dropped, one-cycle pulse.
  - data_in_sel  out  2  00 pmem, 01 CPU, 11 prefetcher.
  - pmem_addr_sel  out  1  0 victim address, 1 request address.
  - wr_en_data_0_sel  out  2  00 none, 01 full line, 10 byte enables.
  - wr_en_data_1_sel  out  2  same encoding for way 1.
  - dirty_in  out  1  dirty value to write.
  - valid_in  out  1  valid value to write.
  - ld_dirty_0, ld_dirty_1  out  1 each  dirty array loads.
  - ld_valid_0, ld_valid_1  out  1 each  valid array loads.
  - ld_tag_0, ld_tag_1  out  1 each  tag array loads.
  - ld_lru  out  1  LRU update; datapath writes ~way.
  - index_sel  out  1  0 CPU index, 1 prefetch index.
  - tag_sel  out  1  0 CPU tag, 1 prefetch tag.

Function
- REQ-003 SHALL use a Moore/Mealy FSM with states IDLE, CHECK, WB, FILL, PF_CHECK, PF_WB, PF_FILL.
- REQ-004 Every output SHALL default to 0 in every state unless driven by REQ-005..REQ-011.
- REQ-005 IDLE, arbitration:
  - CPU request present and (no prefetch_ready or starve count < PF_STARVE_LIMIT) -> CHECK.
  - Otherwise prefetch_ready -> PF_CHECK.
  - Neither -> stay in IDLE.
- REQ-006 CHECK, hit (miss=0):
  - mem_resp=1, ld_lru=1, next state IDLE.
  - On write, additionally: data_in_sel=01, wr_en sel of the hit way=10, ld_dirty of that way=1, dirty_in=1.
- REQ-007 CHECK, miss: next state WB if dirty_out=1, else FILL.
- REQ-008 WB:
  - pmem_write=1, pmem_addr_sel=0, until pmem_resp.
  - Next state FILL.
- REQ-009 FILL:
  - pmem_read=1, pmem_addr_sel=1.
  - On pmem_resp: data_in_sel=00; wr_en sel of way=01; ld_tag, ld_valid, ld_dirty of way=1; valid_in=1, dirty_in=0; next state CHECK.
  - Read-miss latency is therefore one CHECK cycle after the fill.
- REQ-010 PF_CHECK, PF_WB, PF_FILL SHALL drive index_sel=1, tag_sel=1.
  - PF_CHECK hit: prefetch_ack=1, no array writes, next state IDLE (duplicate dropped).
  - PF_CHECK miss: next state PF_WB if dirty_out=1, else PF_FILL.
  - PF_WB: identical to WB, then PF_FILL.
- REQ-011 PF_FILL, single cycle:
  - data_in_sel=11; wr_en sel of way=01; ld_tag, ld_valid, ld_dirty=1; valid_in=1, dirty_in=0.
  - prefetch_ack=1, ld_lru=0 (prefetched line stays LRU-eligible), next state IDLE.
- REQ-012 Starve counter:
  - Increments on each IDLE->CHECK transition while prefetch_ready=1.
  - Clears on IDLE->PF_CHECK or when prefetch_ready=0.
  - Saturates at PF_STARVE_LIMIT.
- REQ-013 pmem_read and pmem_write SHALL never be asserted together, and SHALL remain stable until pmem_resp.
- REQ-014 A CPU request arriving during any PF_* state SHALL wait; it SHALL NOT abort the prefetch sequence.

Reset
- REQ-015 rst=0 SHALL asynchronously force state IDLE, clear the starve counter, and drive all outputs to 0.
- REQ-016 Reset mid-WB or mid-FILL SHALL drop the transaction; no array load SHALL occur in the reset cycle.

Structure
- REQ-017 A shared package prefetch_cache_pkg SHALL hold:
  - the state enum;
  - data_in_sel encodings;
  - wr_en sel encodings;
  - pmem_addr_sel encodings.
- REQ-018 SHALL be a single module with no sub-module; the starve counter stays inline.

Verification
- REQ-019 Read hit way 1: mem_read, miss=0, way=1 -> mem_resp in CHECK, ld_lru=1, no pmem activity.
- REQ-020 Write miss, dirty victim:
  - Expected sequence: WB (pmem_write, pmem_addr_sel=0), then FILL (pmem_read, wr_en sel 01), then CHECK write (wr_en sel 10, dirty_in=1), then mem_resp.
- REQ-021 prefetch_ready with no CPU request, PF_CHECK miss, clean victim -> PF_FILL: data_in_sel=11, prefetch_ack, ld_lru=0.
- REQ-022 prefetch_ready held while CPU issues 5 back-to-back hits, PF_STARVE_LIMIT=4 -> 4 CPU grants, then PF_CHECK before the 5th.
- REQ-023 rst=0 while in FILL with pmem_read=1 -> outputs 0 immediately; after reset release, FSM in IDLE and no ld_* pulse.
